// File: rtl/data_mem_ws.sv
// data_mem_ws: word-addressed 32-bit data RAM with byte enables, a
// programmable number of wait states and a ready/error completion pulse.
// A request is latched in IDLE, ages through WAIT and is performed in DONE.
// Misaligned or out-of-range requests complete with err_o and touch nothing.
// The verify tap mirrors one word and the access counters saturate for
// end-of-run reporting.
module data_mem_ws #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int VERIFY_WORD = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [31:0]          addr,
    input  logic [31:0]          data_i,
    output logic [31:0]          data_o,
    output logic                 ready_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic [31:0]          verify,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t         state;
    logic [3:0]     wait_cnt;
    logic           we_q;
    logic [3:0]     be_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic [AW-1:0]  word_idx;
    logic           misaligned;
    logic           out_of_range;
    logic           access_err;
    logic [31:0]    ram_word;
    logic [31:0]    merged_word;
    logic           ram_write;

    // Decode the latched request and build the byte-merged write word
    always_comb begin
        word_idx     = addr_q[AW+1:2];
        misaligned   = (addr_q[1:0] != 2'b00);
        out_of_range = ({1'b0, addr_q[31:2]} >= 31'(DEPTH_WORDS));
        access_err   = misaligned | out_of_range;
        ram_word     = mem[word_idx];
        merged_word  = ram_word;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged_word[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
        ram_write    = (state == DONE) && we_q && !access_err;
    end

    // RAM array update; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (ram_write) begin
            mem[word_idx] <= merged_word;
        end
    end

    // Request FSM with registered handshake, read data, verify tap and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_o   <= '0;
            ready_o  <= 1'b0;
            err_o    <= 1'b0;
            busy_o   <= 1'b0;
            verify   <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            ready_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ce) begin
                        we_q     <= we;
                        be_q     <= be;
                        addr_q   <= addr;
                        wdata_q  <= data_i;
                        wait_cnt <= 4'(LATENCY - 1);
                        busy_o   <= 1'b1;
                        state    <= (LATENCY > 1) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                    if (access_err) begin
                        err_o  <= 1'b1;
                        data_o <= '0;
                    end else if (we_q) begin
                        if (wr_count != '1) begin
                            wr_count <= wr_count + 1'b1;
                        end
                        if (word_idx == AW'(VERIFY_WORD)) begin
                            verify <= merged_word;
                        end
                    end else begin
                        data_o <= ram_word;
                        if (rd_count != '1) begin
                            rd_count <= rd_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ws.sv
// tb_data_mem_ws: directed self-checking bench for data_mem_ws with
// LATENCY=2, DEPTH_WORDS=1024, VERIFY_WORD=0 and 2-bit access counters.
module tb_data_mem_ws;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        err_o;
    logic        busy_o;
    logic [31:0] verify;
    logic [1:0]  rd_count;
    logic [1:0]  wr_count;

    int          tests;
    int          fails;
    logic [31:0] rdata;
    logic        rerr;
    int          lat;

    data_mem_ws #(
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT),
        .VERIFY_WORD (0),
        .CNT_WIDTH   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .we       (we),
        .be       (be),
        .addr     (addr),
        .data_i   (data_i),
        .data_o   (data_o),
        .ready_o  (ready_o),
        .err_o    (err_o),
        .busy_o   (busy_o),
        .verify   (verify),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Issue one request, wait (bounded) for its completion pulse and return the result
    task automatic applyStimulus(input logic w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rd, output logic re,
                                 output int cycles);
        @(negedge clk);
        ce     = 1'b1;
        we     = w;
        be     = b;
        addr   = a;
        data_i = d;
        @(posedge clk);
        #1;
        ce     = 1'b0;
        cycles = 0;
        while (!ready_o && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("ready seen", 32'(ready_o), 32'd1);
        checkOutput("latency", 32'(cycles), 32'(LAT));
        rd = data_o;
        re = err_o;
    endtask

    initial begin
        int ready_cnt;
        int last_ready;
        tests  = 0;
        fails  = 0;
        rst    = 1'b0;
        ce     = 1'b0;
        we     = 1'b0;
        be     = 4'h0;
        addr   = 32'h0;
        data_i = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset data_o", data_o, 32'h0);
        checkOutput("reset ready", 32'(ready_o), 32'h0);
        checkOutput("reset err", 32'(err_o), 32'h0);
        checkOutput("reset busy", 32'(busy_o), 32'h0);
        checkOutput("reset verify", verify, 32'h0);
        checkOutput("reset rd_count", 32'(rd_count), 32'h0);
        checkOutput("reset wr_count", 32'(wr_count), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Full-word write then read back
        applyStimulus(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rdata, rerr, lat);
        checkOutput("wr 0x10 err", 32'(rerr), 32'h0);
        applyStimulus(1'b0, 4'h0, 32'h10, 32'h0, rdata, rerr, lat);
        checkOutput("rd 0x10 data", rdata, 32'hDEADBEEF);
        checkOutput("rd 0x10 err", 32'(rerr), 32'h0);
        checkOutput("rd_count after 1 rd", 32'(rd_count), 32'd1);
        checkOutput("wr_count after 1 wr", 32'(wr_count), 32'd1);

        // Byte-enable merge
        applyStimulus(1'b1, 4'hF, 32'h20, 32'h11223344, rdata, rerr, lat);
        applyStimulus(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rdata, rerr, lat);
        applyStimulus(1'b0, 4'h0, 32'h20, 32'h0, rdata, rerr, lat);
        checkOutput("rd 0x20 merged", rdata, 32'h11BB33DD);
        checkOutput("wr_count after 3 wr", 32'(wr_count), 32'd3);

        // Misaligned and out-of-range reads
        applyStimulus(1'b0, 4'h0, 32'h13, 32'h0, rdata, rerr, lat);
        checkOutput("rd 0x13 err", 32'(rerr), 32'h1);
        checkOutput("rd 0x13 data", rdata, 32'h0);
        checkOutput("rd_count after misaligned", 32'(rd_count), 32'd2);
        applyStimulus(1'b0, 4'h0, 32'h1000, 32'h0, rdata, rerr, lat);
        checkOutput("rd 0x1000 err", 32'(rerr), 32'h1);
        checkOutput("rd_count after oor", 32'(rd_count), 32'd2);

        // Verify tap and write counter saturation
        applyStimulus(1'b1, 4'hF, 32'h0, 32'h00000037, rdata, rerr, lat);
        checkOutput("verify after wr 0x0", verify, 32'h00000037);
        checkOutput("wr_count saturated", 32'(wr_count), 32'd3);
        applyStimulus(1'b1, 4'hF, 32'h4, 32'h00000099, rdata, rerr, lat);
        checkOutput("verify after wr 0x4", verify, 32'h00000037);

        // Reset in the middle of a write leaves the old contents
        applyStimulus(1'b1, 4'hF, 32'h8, 32'h12345678, rdata, rerr, lat);
        applyStimulus(1'b0, 4'h0, 32'h20, 32'h0, rdata, rerr, lat);
        @(negedge clk);
        ce     = 1'b1;
        we     = 1'b1;
        be     = 4'hF;
        addr   = 32'h8;
        data_i = 32'h00000055;
        @(posedge clk);
        #1;
        ce = 1'b0;
        checkOutput("busy in WAIT", 32'(busy_o), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy_o), 32'h0);
        checkOutput("abort ready", 32'(ready_o), 32'h0);
        checkOutput("abort data_o", data_o, 32'h0);
        checkOutput("abort verify", verify, 32'h0);
        checkOutput("abort wr_count", 32'(wr_count), 32'h0);
        checkOutput("abort rd_count", 32'(rd_count), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held reset ready", 32'(ready_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 4'h0, 32'h8, 32'h0, rdata, rerr, lat);
        checkOutput("rd 0x8 old data", rdata, 32'h12345678);
        checkOutput("wr_count after abort", 32'(wr_count), 32'h0);

        // Read counter saturation
        applyStimulus(1'b0, 4'h0, 32'h10, 32'h0, rdata, rerr, lat);
        checkOutput("rd_count 2", 32'(rd_count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'h0, 32'h10, 32'h0, rdata, rerr, lat);
        end
        checkOutput("rd 0x10 again", rdata, 32'hDEADBEEF);
        checkOutput("rd_count saturated", 32'(rd_count), 32'd3);

        // Continuous ce: one completion every LAT+1 cycles
        @(negedge clk);
        ce   = 1'b1;
        we   = 1'b0;
        be   = 4'h0;
        addr = 32'h10;
        ready_cnt  = 0;
        last_ready = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                ready_cnt++;
                checkOutput("stream spacing", 32'(k - last_ready), 32'(LAT + 1));
                checkOutput("stream data", data_o, 32'hDEADBEEF);
                last_ready = k;
            end
        end
        ce = 1'b0;
        checkOutput("stream ready count", 32'(ready_cnt), 32'd10);
        checkOutput("stream rd_count", 32'(rd_count), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_ws.md
Name: data_mem_ws

Overview:
- Parametrised successor to the single-cycle SoC data memory.
- Word-addressed 32-bit RAM with byte enables, a configurable number of wait states and a ready/error handshake.
- Keeps the `verify` result tap and adds saturating read/write access counters for end-of-run reporting by the SoC bench.
- Sits on the core's data port (`data_ce_o`/`data_we_o`/`data_addr_o`/`data_o`/`data_i`). The core must stall until `ready_o`.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, at least 2.
- LATENCY, 2, cycles from request acceptance to `ready_o`; legal range 1..15.
- VERIFY_WORD, 0, word index mirrored onto `verify`.
- CNT_WIDTH, 16, width of each access counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  request valid.
- we  in  1  1 = write, 0 = read; sampled with `ce`.
- be  in  4  byte enables for writes; `be[i]` selects `data_i[8i+7:8i]`.
- addr  in  32  byte address.
- data_i  in  32  write data.
- data_o  out  32  read data; valid while `ready_o`=1.
- ready_o  out  1  one-cycle completion pulse.
- err_o  out  1  completion with error; only ever high together with `ready_o`.
- busy_o  out  1  request in flight; new requests are not accepted.
- verify  out  32  registered copy of word VERIFY_WORD.
- rd_count  out  CNT_WIDTH  completed good reads, saturating at all-ones.
- wr_count  out  CNT_WIDTH  completed good writes, saturating at all-ones.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - FSM goes to IDLE.
  - `data_o`, `verify`, `rd_count`, `wr_count` = 0.
  - `ready_o`, `err_o`, `busy_o` = 0.
  - RAM contents are not reset.
  - Reset mid-operation aborts the request; no write occurs.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If `ce`=1, latch `addr`, `we`, `be`, `data_i`.
  - Load the wait counter with LATENCY-1.
  - `busy_o` goes 1 on the next cycle.
  - Next state is WAIT if LATENCY>1, otherwise DONE.
- WAIT:
  - Decrement the counter.
  - Move to DONE when the counter reaches 0.
  - `ce` is ignored; the core must hold it.
- DONE (one cycle):
  - Perform the access.
  - Assert `ready_o`=1 for exactly one cycle.
  - Return to IDLE; `busy_o` falls in the same cycle `ready_o` rises.
- Latency: the edge that samples `ce`=1 in IDLE is N. `ready_o` is high in the cycle after edge N+LATENCY.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately following `ready_o`. Sustained throughput is one request per LATENCY+1 cycles.
- Error decode, on the latched address:
  - Misaligned: `addr[1:0]` != 0.
  - Out of range: `addr[31:2]` >= DEPTH_WORDS.
  - Either condition gives `err_o`=1 with `ready_o`, `data_o`=0, no RAM write and no counter increment.
- Write, good:
  - Update only the enabled bytes.
  - If `be`=0, complete normally, write nothing, still increment `wr_count`.
  - If the word index equals VERIFY_WORD, update `verify` with the merged word on the same edge.
- Read, good:
  - `data_o` = RAM word, registered.
  - `be` is ignored.
  - Increment `rd_count`.
- `data_o` holds its last value when `ready_o`=0.
- Counters stop at 2^CNT_WIDTH-1; no wrap.
- The DONE-cycle write and a new request's read are never simultaneous, so no RAM read/write collision is possible.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 with `be`=1111 (LATENCY=2) → `ready_o` at the 3rd cycle after acceptance. Read 0x10 → `data_o`=0xDEADBEEF, `err_o`=0. Afterwards `rd_count`=1, `wr_count`=1.
- Write 0x11223344 then 0xAABBCCDD with `be`=0101 to 0x20 → read returns 0x11BB33DD.
- Read 0x13 → `err_o`=1, `data_o`=0, `rd_count` unchanged. Read 0x1000 with DEPTH_WORDS=1024 → `err_o`=1.
- Write 0x00000037 to word VERIFY_WORD (address 0x0) → `verify`=0x00000037 from the completion edge onward. A write to 0x4 leaves `verify` unchanged.
- Assert `rst`=0 during WAIT of a write of 0x55 to 0x8, then release and read 0x8 → old contents returned, all outputs 0 during reset, `wr_count`=0.
- With CNT_WIDTH=2, perform 5 reads → `rd_count` saturates at 3. Hold `ce`=1 continuously → exactly one `ready_o` per LATENCY+1 cycles.
